elevator_group_ctrl: RTL and testbench

Parametrised multi-car elevator group controller: NUM_CARS cars serving NUM_FLOORS floors.
- Hall requests enter through a valid/ready port. The dispatcher assigns each request to the nearest car as a pending stop.
- Each car runs a SCAN-style FSM with timed travel and door dwell.
- Sits under top-level integration in place of the fixed 3-car, 3-bit floor logic.

---
 rtl/elevator_pkg.sv | 22 ++
 rtl/elevator_car.sv | 221 ++++++++++++++++++++++
 rtl/elevator_group_ctrl.sv | 90 +++++++++
 tb/tb_elevator_group_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg
// Shared types, constants and helpers for the elevator group controller.
//   car_state_e  : per-car FSM state encoding
//   PARK_TIMEOUT : idle cycles before an empty car returns to floor 0.
//                  Only used when ELEV_PARK_EN is defined.
//   floor_dist   : absolute floor distance used by the dispatcher
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } car_state_e;

    localparam int PARK_TIMEOUT = 16;

    function automatic int floor_dist(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/elevator_car.sv
// elevator_car
// One elevator car. It holds a SCAN-style FSM, a stop mask, a shared
// travel/door counter and, optionally, park-to-ground logic.
// Optional macro: ELEV_PARK_EN. When it is defined, a car that has been idle
// with an empty mask for PARK_TIMEOUT cycles moves down to floor 0 with its
// door kept closed.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   set_en     : add a stop at set_floor on this edge
//   set_floor  : floor index of the stop to add
//   floor      : current floor
//   moving     : car is in MOVE_UP or MOVE_DOWN
//   dir_up     : last or current travel direction is up
//   door_open  : car is in DOOR_OPEN
//   mask       : pending stop mask, one bit per floor
module elevator_car
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 4,
    localparam int FW = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [FW-1:0]         set_floor,
    output logic [FW-1:0]         floor,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] mask
);

    localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

    car_state_e            state, state_n;
    logic [FW-1:0]         cur_floor, floor_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  dir_q, dir_n;
    logic [NUM_FLOORS-1:0] stops, set_vec, clr_vec;
    logic                  clr_en, decide;
    logic [FW-1:0]         eval_f;
    logic                  eval_here, eval_above, eval_below;

`ifdef ELEV_PARK_EN
    localparam int IW = $clog2(PARK_TIMEOUT);
    localparam logic [IW-1:0] PARK_LAST = IW'(PARK_TIMEOUT - 1);
    logic          parking, park_n;
    logic [IW-1:0] idle_cnt;
`endif

    function automatic logic stops_above(input logic [NUM_FLOORS-1:0] m,
                                         input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (m[i] && (i > int'(f))) r = 1'b1;
        return r;
    endfunction

    function automatic logic stops_below(input logic [NUM_FLOORS-1:0] m,
                                         input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (m[i] && (i < int'(f))) r = 1'b1;
        return r;
    endfunction

    // The floor where the next decision is taken. For a moving car this is
    // the floor it is about to arrive at. For a stationary car it is the
    // floor it is on. The range guards keep the car inside the building.
    always_comb begin
        eval_f = cur_floor;
        if (state == MOVE_UP && cur_floor != TOP_FLOOR)
            eval_f = cur_floor + FW'(1);
        else if (state == MOVE_DOWN && cur_floor != '0)
            eval_f = cur_floor - FW'(1);
    end

    assign eval_here  = stops[eval_f];
    assign eval_above = stops_above(stops, eval_f);
    assign eval_below = stops_below(stops, eval_f);

    // Next-state logic. Arrival at a floor and the end of the door dwell
    // share one decision. That decision serves the current floor first, so a
    // request made while the door is open reopens the door. Otherwise the car
    // keeps its direction while stops lie ahead and reverses only when all
    // remaining stops are behind it.
    always_comb begin
        state_n = state;
        floor_n = cur_floor;
        cnt_n   = cnt;
        dir_n   = dir_q;
        clr_en  = 1'b0;
        decide  = 1'b0;
`ifdef ELEV_PARK_EN
        park_n  = parking;
`endif
        case (state)
            IDLE: begin
                if (eval_here) begin
                    state_n = DOOR_OPEN;
                    cnt_n   = '0;
                    clr_en  = 1'b1;
                end else if (eval_above) begin
                    state_n = MOVE_UP;
                    dir_n   = 1'b1;
                    cnt_n   = '0;
                end else if (eval_below) begin
                    state_n = MOVE_DOWN;
                    dir_n   = 1'b0;
                    cnt_n   = '0;
                end
`ifdef ELEV_PARK_EN
                else if (idle_cnt == PARK_LAST && cur_floor != '0) begin
                    state_n = MOVE_DOWN;
                    dir_n   = 1'b0;
                    cnt_n   = '0;
                    park_n  = 1'b1;
                end
`endif
            end
            MOVE_UP, MOVE_DOWN: begin
                if (cnt == MOVE_LAST) begin
                    floor_n = eval_f;
                    cnt_n   = '0;
                    decide  = 1'b1;
`ifdef ELEV_PARK_EN
                    if (stops != '0) park_n = 1'b0;
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DOOR_OPEN: begin
                if (cnt == DOOR_LAST) begin
                    cnt_n  = '0;
                    decide = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (decide) begin
            if (eval_here) begin
                state_n = DOOR_OPEN;
                clr_en  = 1'b1;
            end else if (dir_q ? eval_above : eval_below) begin
                state_n = dir_q ? MOVE_UP : MOVE_DOWN;
            end else if (dir_q ? eval_below : eval_above) begin
                state_n = dir_q ? MOVE_DOWN : MOVE_UP;
                dir_n   = ~dir_q;
            end
`ifdef ELEV_PARK_EN
            else if (park_n && eval_f != '0) begin
                state_n = MOVE_DOWN;
            end
`endif
            else begin
                state_n = IDLE;
            end
        end

`ifdef ELEV_PARK_EN
        if (state_n != MOVE_DOWN) park_n = 1'b0;
`endif
    end

    // The clear is applied after the set. If both hit the same bit in one
    // cycle, the door opening counts as serving that request.
    assign set_vec = set_en ? (NUM_FLOORS'(1) << set_floor) : '0;
    assign clr_vec = clr_en ? (NUM_FLOORS'(1) << eval_f)    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_floor <= '0;
            cnt       <= '0;
            dir_q     <= 1'b1;
            stops     <= '0;
        end else begin
            state     <= state_n;
            cur_floor <= floor_n;
            cnt       <= cnt_n;
            dir_q     <= dir_n;
            stops     <= (stops | set_vec) & ~clr_vec;
        end
    end

`ifdef ELEV_PARK_EN
    // Counts consecutive idle cycles with nothing to do. The count saturates
    // so that a car already on floor 0 does not wrap around.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
            parking  <= 1'b0;
        end else begin
            parking <= park_n;
            if (state == IDLE && state_n == IDLE && stops == '0)
                idle_cnt <= (idle_cnt == PARK_LAST) ? idle_cnt : idle_cnt + IW'(1);
            else
                idle_cnt <= '0;
        end
    end
`endif

    assign floor     = cur_floor;
    assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign dir_up    = dir_q;
    assign door_open = (state == DOOR_OPEN);
    assign mask      = stops;

endmodule

// File: rtl/elevator_group_ctrl.sv
// elevator_group_ctrl
// Multi-car elevator group. Each hall request is given to the nearest car;
// a tie goes to the lowest car index. A request for a floor that is already
// pending in any car is absorbed. A request for an out-of-range floor is
// dropped and flagged on req_err.
// Optional macro: ELEV_PARK_EN. It enables the park-to-ground behaviour in
// every car.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   req_valid  : hall request valid
//   req_floor  : requested floor index
//   req_ready  : request accept, low only while rst is high
//   req_err    : one-cycle pulse after an out-of-range request is accepted
//   car_floor  : current floor per car, car i at [i*FW +: FW]
//   car_moving : car is travelling
//   car_dir_up : last or current direction is up
//   door_open  : car door is open
module elevator_group_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_CARS    = 3,
    parameter int NUM_FLOORS  = 8,
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 4,
    localparam int FW = $clog2(NUM_FLOORS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [FW-1:0]          req_floor,
    output logic                   req_ready,
    output logic                   req_err,
    output logic [NUM_CARS*FW-1:0] car_floor,
    output logic [NUM_CARS-1:0]    car_moving,
    output logic [NUM_CARS-1:0]    car_dir_up,
    output logic [NUM_CARS-1:0]    door_open
);

    logic [FW-1:0]         floor_arr [NUM_CARS];
    logic [NUM_FLOORS-1:0] mask_arr  [NUM_CARS];
    logic [NUM_CARS-1:0]   set_en;
    logic                  accept, in_range, absorbed;
    int                    best_idx, best_d;

    assign req_ready = ~rst;
    assign accept    = req_valid & req_ready;
    assign in_range  = int'(req_floor) < NUM_FLOORS;

    // Dispatcher. It uses a strict less-than, so the first car found at the
    // minimum distance keeps the request. Car state is ignored on purpose.
    always_comb begin
        absorbed = 1'b0;
        best_idx = 0;
        best_d   = NUM_FLOORS;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (in_range && mask_arr[i][req_floor]) absorbed = 1'b1;
            if (floor_dist(int'(floor_arr[i]), int'(req_floor)) < best_d) begin
                best_d   = floor_dist(int'(floor_arr[i]), int'(req_floor));
                best_idx = i;
            end
        end
        for (int i = 0; i < NUM_CARS; i++)
            set_en[i] = accept & in_range & ~absorbed & (best_idx == i);
    end

    always_ff @(posedge clk) begin
        if (rst) req_err <= 1'b0;
        else     req_err <= accept & ~in_range;
    end

    for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
        elevator_car #(
            .NUM_FLOORS  (NUM_FLOORS),
            .MOVE_CYCLES (MOVE_CYCLES),
            .DOOR_CYCLES (DOOR_CYCLES)
        ) u_car (
            .clk       (clk),
            .rst       (rst),
            .set_en    (set_en[i]),
            .set_floor (req_floor),
            .floor     (floor_arr[i]),
            .moving    (car_moving[i]),
            .dir_up    (car_dir_up[i]),
            .door_open (door_open[i]),
            .mask      (mask_arr[i])
        );
        assign car_floor[i*FW +: FW] = floor_arr[i];
    end

endmodule

// File: tb/tb_elevator_group_ctrl.sv
// tb_elevator_group_ctrl
// Self-checking bench for elevator_group_ctrl. It uses 7 floors, so floor
// index 7 is out of range. A behavioural model steps at every clock edge,
// and one compare process checks all DUT outputs at every falling edge.
// Directed scenarios add hand-computed literal expectations. Randomized
// traffic, with occasional resets, follows the directed scenarios.
module tb_elevator_group_ctrl;

    localparam int NC = 3;
    localparam int NF = 7;
    localparam int MC = 2;
    localparam int DC = 4;
    localparam int FW = $clog2(NF);

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [FW-1:0]    req_floor;
    logic             req_ready;
    logic             req_err;
    logic [NC*FW-1:0] car_floor;
    logic [NC-1:0]    car_moving;
    logic [NC-1:0]    car_dir_up;
    logic [NC-1:0]    door_open;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    elevator_group_ctrl #(
        .NUM_CARS    (NC),
        .NUM_FLOORS  (NF),
        .MOVE_CYCLES (MC),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_floor  (req_floor),
        .req_ready  (req_ready),
        .req_err    (req_err),
        .car_floor  (car_floor),
        .car_moving (car_moving),
        .car_dir_up (car_dir_up),
        .door_open  (door_open)
    );

    // Behavioural model. Mode 0 is standing idle, mode 1 is travelling and
    // mode 2 is door open. m_left holds the edges remaining in the current
    // leg or dwell.
    int          m_floor [NC];
    int          m_mode  [NC];
    int          m_left  [NC];
    int          m_clr   [NC];
    bit          m_dir   [NC];
    bit [NF-1:0] m_stops [NC];
    bit          m_err;
    int          tgt, bestd;
    bit          absorbed;

    function automatic bit stopsToward(int c, bit up);
        for (int f = 0; f < NF; f++)
            if (m_stops[c][f] && (up ? (f > m_floor[c]) : (f < m_floor[c]))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void openDoor(int c);
        m_mode[c] = 2;
        m_left[c] = DC;
        m_stops[c][m_floor[c]] = 1'b0;
        m_clr[c] = m_floor[c];
    endfunction

    function automatic void startLeg(int c, bit up);
        m_mode[c] = 1;
        m_dir[c]  = up;
        m_left[c] = MC;
    endfunction

    function automatic void pickNext(int c);
        if (m_stops[c][m_floor[c]])         openDoor(c);
        else if (stopsToward(c, m_dir[c]))  startLeg(c, m_dir[c]);
        else if (stopsToward(c, !m_dir[c])) startLeg(c, !m_dir[c]);
        else                                m_mode[c] = 0;
    endfunction

    function automatic void stepCar(int c);
        if (m_mode[c] == 0) begin
            if (m_stops[c][m_floor[c]])  openDoor(c);
            else if (stopsToward(c, 1)) startLeg(c, 1'b1);
            else if (stopsToward(c, 0)) startLeg(c, 1'b0);
        end else begin
            m_left[c]--;
            if (m_left[c] == 0) begin
                if (m_mode[c] == 1) m_floor[c] += m_dir[c] ? 1 : -1;
                pickNext(c);
            end
        end
    endfunction

    function automatic bit modelIdle();
        for (int c = 0; c < NC; c++)
            if (m_mode[c] != 0 || m_stops[c] != '0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model_step
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_floor[c] = 0;
                m_mode[c]  = 0;
                m_left[c]  = 0;
                m_dir[c]   = 1'b1;
                m_stops[c] = '0;
            end
            m_err = 1'b0;
        end else begin
            m_err = req_valid && (int'(req_floor) >= NF);
            tgt = -1;
            if (req_valid && int'(req_floor) < NF) begin
                absorbed = 1'b0;
                for (int c = 0; c < NC; c++)
                    if (m_stops[c][req_floor]) absorbed = 1'b1;
                if (!absorbed) begin
                    bestd = NF + 1;
                    for (int c = 0; c < NC; c++) begin
                        if ((m_floor[c] > int'(req_floor) ? m_floor[c] - int'(req_floor)
                                                          : int'(req_floor) - m_floor[c]) < bestd) begin
                            bestd = (m_floor[c] > int'(req_floor) ? m_floor[c] - int'(req_floor)
                                                                  : int'(req_floor) - m_floor[c]);
                            tgt = c;
                        end
                    end
                end
            end
            for (int c = 0; c < NC; c++) begin
                m_clr[c] = -1;
                stepCar(c);
            end
            if (tgt >= 0 && m_clr[tgt] != int'(req_floor))
                m_stops[tgt][req_floor] = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    function automatic int dutFloor(int c);
        return int'(car_floor[c*FW +: FW]);
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            for (int c = 0; c < NC; c++) begin
                checkOutput($sformatf("model car%0d floor", c), dutFloor(c), m_floor[c]);
                checkOutput($sformatf("model car%0d moving", c), int'(car_moving[c]), (m_mode[c] == 1) ? 1 : 0);
                checkOutput($sformatf("model car%0d dir_up", c), int'(car_dir_up[c]), int'(m_dir[c]));
                checkOutput($sformatf("model car%0d door", c), int'(door_open[c]), (m_mode[c] == 2) ? 1 : 0);
            end
            checkOutput("model req_err", int'(req_err), int'(m_err));
            checkOutput("model req_ready", int'(req_ready), rst ? 0 : 1);
        end
    end

    task automatic applyStimulus(input bit v, input int f, input bit r);
        req_valid = v;
        req_floor = f[FW-1:0];
        rst       = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!modelIdle() && n < 100) begin
            applyStimulus(1'b0, 0, 1'b0);
            n++;
        end
        if (n >= 100) checkOutput("wait idle timeout", n, 0);
    endtask

    int mv, dr, other, opens;
    bit prev, rnd_rst, rnd_v;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_floor = '0;

        // Reset is held for two cycles and then released.
        applyStimulus(1'b0, 0, 1'b1);
        check_en = 1'b1;
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("reset ready low", int'(req_ready), 0);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("reset floors", int'(car_floor), 0);
        checkOutput("reset door", int'(door_open), 0);
        checkOutput("reset moving", int'(car_moving), 0);
        checkOutput("reset dir_up", int'(car_dir_up), 7);
        checkOutput("reset ready", int'(req_ready), 1);

        // Request floor 3. Every car is at distance 3, so the tie goes to car 0.
        applyStimulus(1'b1, 3, 1'b0);
        checkOutput("t2 still idle at accept", int'(car_moving[0]), 0);
        mv = 0; dr = 0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 0, 1'b0);
            if (car_moving[0]) mv++;
            if (door_open[0]) dr++;
            if (k == 3) checkOutput("t2 floor after 1 leg", dutFloor(0), 1);
            if (k == 5) checkOutput("t2 floor after 2 legs", dutFloor(0), 2);
            if (k == 7) begin
                checkOutput("t2 arrive floor", dutFloor(0), 3);
                checkOutput("t2 door on arrival", int'(door_open[0]), 1);
            end
        end
        checkOutput("t2 moving cycles", mv, 6);
        checkOutput("t2 door cycles", dr, 4);
        checkOutput("t2 car1 untouched", dutFloor(1), 0);

        // Park car 0 at floor 5, then request floor 4. Car 0 is nearest.
        applyStimulus(1'b1, 5, 1'b0);
        waitIdle();
        checkOutput("t3 parked at 5", dutFloor(0), 5);
        applyStimulus(1'b1, 4, 1'b0);
        mv = 0; other = 0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 0, 1'b0);
            if (car_moving[0]) mv++;
            if (car_moving[1] || car_moving[2]) other++;
        end
        checkOutput("t3 moving cycles", mv, 2);
        checkOutput("t3 other cars moved", other, 0);
        checkOutput("t3 car0 floor", dutFloor(0), 4);

        // Two back-to-back requests for floor 6 give one stop and one door opening.
        applyStimulus(1'b1, 6, 1'b0);
        applyStimulus(1'b1, 6, 1'b0);
        opens = 0; prev = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 0, 1'b0);
            if (door_open[0] && !prev) opens++;
            prev = door_open[0];
        end
        checkOutput("t4 door openings", opens, 1);
        checkOutput("t4 car0 floor", dutFloor(0), 6);

        // An out-of-range floor gives a one-cycle error pulse and nothing else.
        applyStimulus(1'b1, 7, 1'b0);
        checkOutput("t5 err pulse", int'(req_err), 1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t5 err cleared", int'(req_err), 0);
        checkOutput("t5 car0 unchanged", dutFloor(0), 6);

        // Reset arrives mid-leg between floors 2 and 3.
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b1, 3, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t6 floor before reset", dutFloor(0), 2);
        checkOutput("t6 moving before reset", int'(car_moving[0]), 1);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("t6 floor after reset", dutFloor(0), 0);
        checkOutput("t6 moving after reset", int'(car_moving[0]), 0);
        mv = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 0, 1'b0);
            if (car_moving != '0 || door_open != '0) mv++;
        end
        checkOutput("t6 stops lost", mv, 0);
        applyStimulus(1'b1, 1, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t6 later request floor", dutFloor(0), 1);
        checkOutput("t6 later request door", int'(door_open[0]), 1);

        // Randomized traffic, including out-of-range floors and rare resets.
        for (int k = 0; k < 1500; k++) begin
            rnd_rst = ($urandom_range(0, 299) == 0);
            rnd_v   = ($urandom_range(0, 99) < 40);
            applyStimulus(rnd_v, $urandom_range(0, NF), rnd_rst);
        end
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
